ball_engine: RTL and testbench



---
 rtl/ball_engine_pkg.sv | 21 ++
 rtl/ball_engine_brick_geom.sv | 22 ++
 rtl/ball_engine.sv | 146 ++++++++++++++
 tb/tb_ball_engine.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ball_engine_pkg.sv
// ball_engine_pkg: screen, brick-grid and paddle geometry shared with the colour generator
package ball_engine_pkg;
  localparam logic [10:0] SCR_W      = 11'd640;
  localparam logic [10:0] SCR_H      = 11'd480;
  localparam logic [10:0] BRICK_W    = 11'd80;
  localparam logic [10:0] BRICK_H    = 11'd50;
  localparam logic [10:0] PADDLE_W   = 11'd160;
  localparam logic [10:0] PADDLE_H   = 11'd10;
  localparam logic [10:0] PADDLE_MID = PADDLE_W >> 1;
  localparam int ROWS   = 3;
  localparam int COLS   = 8;
  localparam int NBRICK = ROWS * COLS;

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT, S_MOVE, S_WALL, S_PADDLE, S_SCAN, S_COMMIT, S_LOST, S_WIN
  } state_t;

  function automatic logic [4:0] brick_idx(input logic [1:0] r, input logic [2:0] c);
    return {r, c};
  endfunction
endpackage

// File: rtl/ball_engine_brick_geom.sv
// brick_geom: origin of brick (row,col) and whether the ball box overlaps it
module brick_geom
  import ball_engine_pkg::*;
#(
  parameter logic [10:0] BRICK_TOP = 11'd40,
  parameter logic [10:0] HALF      = 11'd2
) (
  input  logic [1:0]  row,
  input  logic [2:0]  col,
  input  logic [10:0] nx,
  input  logic [10:0] ny,
  output logic        overlap
);
  logic [10:0] bx, by;
  // Compare edges written without subtracting HALF from the ball so nothing can underflow
  always_comb begin
    bx = 11'(col) * BRICK_W;
    by = BRICK_TOP + 11'(row) * BRICK_H;
    overlap = (nx + HALF > bx) && (nx < bx + BRICK_W + HALF) &&
              (ny + HALF > by) && (ny < by + BRICK_H + HALF);
  end
endmodule

// File: rtl/ball_engine.sv
// ball_engine: once-per-frame ball advance with wall, paddle and brick collision resolution
module ball_engine
  import ball_engine_pkg::*;
#(
  parameter logic [10:0] BRICK_TOP = 11'd40,
  parameter logic [10:0] PADDLE_Y  = 11'd440,
  parameter logic [10:0] BALL_X0   = 11'd320,
  parameter logic [10:0] BALL_Y0   = 11'd300,
  parameter logic [10:0] STEP      = 11'd2,
  parameter logic [10:0] HALF      = 11'd2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              frame_tick,
  input  logic [9:0]        paddlex,
  output logic [9:0]        ballx,
  output logic [9:0]        bally,
  output logic [NBRICK-1:0] hit,
  output logic              busy,
  output logic              game_over,
  output logic              cleared
);
  localparam logic [10:0] X_MIN  = HALF + 11'd1;
  localparam logic [10:0] X_MAX  = SCR_W - HALF - 11'd2;
  localparam logic [10:0] Y_MIN  = HALF + 11'd1;
  localparam logic [10:0] Y_LOST = SCR_H - 11'd1;
  localparam logic [10:0] PAD_UP = PADDLE_Y - HALF - 11'd1;
  localparam logic [10:0] PAD_LO = PADDLE_Y + PADDLE_H;

  state_t      state;
  logic        dx, dy;
  logic [10:0] nx, ny, pad;
  logic [1:0]  row;
  logic [2:0]  col;
  logic        found, overlap;
  logic [4:0]  k;

  assign k = brick_idx(row, col);

  brick_geom #(.BRICK_TOP(BRICK_TOP), .HALF(HALF)) geom (
    .row(row), .col(col), .nx(nx), .ny(ny), .overlap(overlap)
  );

  // Frame sequencer; dx/dy hold 1 for the positive direction, ballx/bally move only on commit or park
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= S_IDLE;
      ballx     <= BALL_X0[9:0];
      bally     <= BALL_Y0[9:0];
      hit       <= '0;
      dx        <= 1'b1;
      dy        <= 1'b0;
      busy      <= 1'b0;
      game_over <= 1'b0;
      cleared   <= 1'b0;
      nx        <= BALL_X0;
      ny        <= BALL_Y0;
      pad       <= '0;
      row       <= '0;
      col       <= '0;
      found     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (!start) state <= S_WAIT;
        S_WAIT: if (frame_tick) begin
          state <= S_MOVE;
          busy  <= 1'b1;
        end
        S_MOVE: begin
          nx    <= dx ? {1'b0, ballx} + STEP : {1'b0, ballx} - STEP;
          ny    <= dy ? {1'b0, bally} + STEP : {1'b0, bally} - STEP;
          pad   <= {1'b0, paddlex};
          state <= S_WALL;
        end
        S_WALL: begin
          if (!dx && nx < X_MIN) begin
            nx <= X_MIN;
            dx <= 1'b1;
          end else if (dx && nx > X_MAX) begin
            nx <= X_MAX;
            dx <= 1'b0;
          end
          if (!dy && ny < Y_MIN) begin
            ny <= Y_MIN;
            dy <= 1'b1;
          end
          if (ny >= Y_LOST) begin
            state     <= S_LOST;
            busy      <= 1'b0;
            game_over <= 1'b1;
            ballx     <= BALL_X0[9:0];
            bally     <= BALL_Y0[9:0];
            dx        <= 1'b1;
            dy        <= 1'b0;
          end else state <= S_PADDLE;
        end
        S_PADDLE: begin
          if (dy && ny + HALF >= PADDLE_Y && ny <= PAD_LO && nx >= pad && nx <= pad + PADDLE_W) begin
            ny <= PAD_UP;
            dy <= 1'b0;
            dx <= nx >= pad + PADDLE_MID;
          end
          row   <= '0;
          col   <= '0;
          found <= 1'b0;
          state <= S_SCAN;
        end
        S_SCAN: begin
          if (overlap && !found && !hit[k]) begin
            hit[k] <= 1'b1;
            dy     <= !dy;
            found  <= 1'b1;
          end
          col <= col + 3'd1;
          if (col == 3'(COLS - 1)) row <= row + 2'd1;
          if (row == 2'(ROWS - 1) && col == 3'(COLS - 1)) state <= S_COMMIT;
        end
        S_COMMIT: begin
          busy <= 1'b0;
          if (&hit) begin
            state   <= S_WIN;
            cleared <= 1'b1;
            ballx   <= BALL_X0[9:0];
            bally   <= BALL_Y0[9:0];
            dx      <= 1'b1;
            dy      <= 1'b0;
          end else begin
            ballx <= nx[9:0];
            bally <= ny[9:0];
            state <= S_WAIT;
          end
        end
        S_LOST: if (!start) begin
          game_over <= 1'b0;
          state     <= S_WAIT;
        end
        S_WIN: if (!start) begin
          hit     <= '0;
          cleared <= 1'b0;
          state   <= S_WAIT;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_ball_engine.sv
// tb_ball_engine: directed and randomized frames checked against a behavioural game model
module tb_ball_engine;
  logic clk = 0, rst = 0, start = 1, frame_tick = 0, start_w = 1, tick_w = 0;
  logic [9:0] paddlex = 0;
  logic [9:0] ballx, bally, ballx_w, bally_w;
  logic [23:0] hit, hit_w;
  logic busy, game_over, cleared, busy_w, game_over_w, cleared_w;
  int total = 0, bad = 0;
  int mx, my, mdx, mdy;
  logic [23:0] mhit;
  bit mlost, mwin;

  ball_engine dut (
    .clk(clk), .rst(rst), .start(start), .frame_tick(frame_tick), .paddlex(paddlex),
    .ballx(ballx), .bally(bally), .hit(hit), .busy(busy), .game_over(game_over), .cleared(cleared)
  );

  ball_engine #(.BALL_X0(11'd635), .BALL_Y0(11'd100)) dut_w (
    .clk(clk), .rst(rst), .start(start_w), .frame_tick(tick_w), .paddlex(paddlex),
    .ballx(ballx_w), .bally(bally_w), .hit(hit_w), .busy(busy_w), .game_over(game_over_w), .cleared(cleared_w)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mx = 320; my = 300; mdx = 1; mdy = -1; mhit = '0; mlost = 0; mwin = 0;
  endtask

  task automatic model_park();
    mx = 320; my = 300; mdx = 1; mdy = -1;
  endtask

  task automatic model_frame(input int pad);
    int nx, ny;
    bit f;
    nx = mx + 2 * mdx;
    ny = my + 2 * mdy;
    if (mdx < 0 && nx < 3) begin nx = 3; mdx = 1; end
    else if (mdx > 0 && nx > 636) begin nx = 636; mdx = -1; end
    if (mdy < 0 && ny < 3) begin ny = 3; mdy = 1; end
    if (ny >= 479) begin
      mlost = 1;
      model_park();
      return;
    end
    if (mdy > 0 && ny + 2 >= 440 && ny <= 450 && nx >= pad && nx <= pad + 160) begin
      ny = 437;
      mdy = -1;
      mdx = (nx < pad + 80) ? -1 : 1;
    end
    f = 0;
    for (int b = 0; b < 24; b++) begin
      int bx, by;
      bx = (b % 8) * 80;
      by = 40 + (b / 8) * 50;
      if (!f && !mhit[b] && nx + 2 > bx && nx - 2 < bx + 80 && ny + 2 > by && ny - 2 < by + 50) begin
        mhit[b] = 1'b1;
        mdy = -mdy;
        f = 1;
      end
    end
    mx = nx;
    my = ny;
    if (&mhit) begin
      mwin = 1;
      model_park();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0; start = 1; frame_tick = 0; start_w = 1; tick_w = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    model_reset();
  endtask

  task automatic serve();
    @(negedge clk) start = 0;
    @(negedge clk) start = 1;
    if (mwin) mhit = '0;
    mlost = 0;
    mwin = 0;
  endtask

  task automatic advance(input int pad, input int inj, output int n);
    paddlex = 10'(pad);
    @(negedge clk) frame_tick = 1;
    @(negedge clk) frame_tick = 0;
    n = 0;
    while (busy && n < 64) begin
      frame_tick = (n == inj);
      @(negedge clk);
      n++;
    end
    frame_tick = 0;
    model_frame(pad);
  endtask

  task automatic test_reset();
    int busy_seen;
    repeat (2) @(negedge clk);
    total++;
    if (ballx !== 10'd320 || bally !== 10'd300 || hit !== 24'h0 || busy !== 1'b0 || game_over !== 1'b0 || cleared !== 1'b0) begin
      bad++;
      $display("FAIL reset_values got x=%0d y=%0d hit=%h busy=%b go=%b cl=%b", ballx, bally, hit, busy, game_over, cleared);
    end
    rst = 1;
    model_reset();
    @(negedge clk) frame_tick = 1;
    @(negedge clk) frame_tick = 0;
    busy_seen = 0;
    repeat (32) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    total++;
    if (busy_seen != 0 || ballx !== 10'd320) begin
      bad++;
      $display("FAIL idle_tick_dropped got busy_cycles=%0d x=%0d want 0 and 320", busy_seen, ballx);
    end
  endtask

  task automatic test_first_frame();
    int n;
    serve();
    advance(0, -1, n);
    total++;
    if (n != 28) begin
      bad++;
      $display("FAIL busy_length got %0d want 28", n);
    end
    total++;
    if (ballx !== 10'd322 || bally !== 10'd298 || hit !== 24'h0) begin
      bad++;
      $display("FAIL first_frame got x=%0d y=%0d hit=%h want 322 298 0", ballx, bally, hit);
    end
  endtask

  task automatic test_brick_and_paddle_left();
    int n;
    for (int f = 2; f <= 180; f++) begin
      advance(546, -1, n);
      total++;
      if (n >= 64 || ballx !== 10'(mx) || bally !== 10'(my) || hit !== mhit || game_over !== mlost) begin
        bad++;
        $display("FAIL play_left f%0d got x=%0d y=%0d hit=%h go=%b want x=%0d y=%0d hit=%h go=%b", f, ballx, bally, hit, game_over, mx, my, mhit, mlost);
      end
      if (f == 55) begin
        total++;
        if (ballx !== 10'd430 || bally !== 10'd190 || hit !== 24'h200000) begin
          bad++;
          $display("FAIL brick21 got x=%0d y=%0d hit=%h want 430 190 200000", ballx, bally, hit);
        end
      end
      if (f == 56) begin
        total++;
        if (bally !== 10'd192) begin
          bad++;
          $display("FAIL brick_bounce got y=%0d want 192", bally);
        end
      end
      if (f == 159 || f == 160) begin
        total++;
        if (ballx !== ((f == 159) ? 10'd636 : 10'd634)) begin
          bad++;
          $display("FAIL right_wall f%0d got x=%0d", f, ballx);
        end
      end
      if (f == 179) begin
        total++;
        if (ballx !== 10'd596 || bally !== 10'd437) begin
          bad++;
          $display("FAIL paddle_hit got x=%0d y=%0d want 596 437", ballx, bally);
        end
      end
      if (f == 180) begin
        total++;
        if (ballx !== 10'd594 || bally !== 10'd435) begin
          bad++;
          $display("FAIL paddle_left_dir got x=%0d y=%0d want 594 435", ballx, bally);
        end
      end
    end
  endtask

  task automatic test_paddle_right();
    int n;
    do_reset();
    serve();
    for (int f = 1; f <= 180; f++) begin
      advance(496, -1, n);
      total++;
      if (n >= 64 || ballx !== 10'(mx) || bally !== 10'(my) || hit !== mhit) begin
        bad++;
        $display("FAIL play_right f%0d got x=%0d y=%0d hit=%h want x=%0d y=%0d hit=%h", f, ballx, bally, hit, mx, my, mhit);
      end
    end
    total++;
    if (ballx !== 10'd598 || bally !== 10'd435) begin
      bad++;
      $display("FAIL paddle_right_dir got x=%0d y=%0d want 598 435", ballx, bally);
    end
  endtask

  task automatic test_lost();
    int n;
    do_reset();
    serve();
    for (int f = 1; f <= 200; f++) begin
      advance(0, -1, n);
      total++;
      if (n >= 64 || ballx !== 10'(mx) || bally !== 10'(my) || hit !== mhit || game_over !== mlost) begin
        bad++;
        $display("FAIL play_lost f%0d got x=%0d y=%0d hit=%h go=%b want x=%0d y=%0d hit=%h go=%b", f, ballx, bally, hit, game_over, mx, my, mhit, mlost);
      end
      if (f == 199) begin
        total++;
        if (bally !== 10'd478 || game_over !== 1'b0) begin
          bad++;
          $display("FAIL pre_lost got y=%0d go=%b want 478 0", bally, game_over);
        end
      end
    end
    total++;
    if (game_over !== 1'b1 || ballx !== 10'd320 || bally !== 10'd300 || hit !== 24'h200000 || busy !== 1'b0) begin
      bad++;
      $display("FAIL lost_state got go=%b x=%0d y=%0d hit=%h busy=%b", game_over, ballx, bally, hit, busy);
    end
    serve();
    @(negedge clk);
    total++;
    if (game_over !== 1'b0 || hit !== 24'h200000) begin
      bad++;
      $display("FAIL reserve got go=%b hit=%h want 0 200000", game_over, hit);
    end
    advance(0, -1, n);
    total++;
    if (ballx !== 10'd322 || bally !== 10'd298) begin
      bad++;
      $display("FAIL reserve_dir got x=%0d y=%0d want 322 298", ballx, bally);
    end
  endtask

  task automatic test_wall();
    int n;
    do_reset();
    @(negedge clk) start_w = 0;
    @(negedge clk) start_w = 1;
    for (int f = 1; f <= 2; f++) begin
      @(negedge clk) tick_w = 1;
      @(negedge clk) tick_w = 0;
      n = 0;
      while (busy_w && n < 64) begin
        @(negedge clk);
        n++;
      end
      total++;
      if (n != 28 || ballx_w !== ((f == 1) ? 10'd636 : 10'd634) || bally_w !== ((f == 1) ? 10'd98 : 10'd100) ||
          hit_w !== 24'h008000 || game_over_w !== 1'b0 || cleared_w !== 1'b0) begin
        bad++;
        $display("FAIL wall_clamp f%0d got n=%0d x=%0d y=%0d hit=%h", f, n, ballx_w, bally_w, hit_w);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    int n;
    do_reset();
    serve();
    for (int f = 0; f < 3; f++) advance(0, -1, n);
    @(negedge clk) frame_tick = 1;
    @(negedge clk) frame_tick = 0;
    repeat (10) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_frame_busy got %b want 1", busy);
    end
    rst = 0;
    #1;
    total++;
    if (ballx !== 10'd320 || bally !== 10'd300 || hit !== 24'h0 || busy !== 1'b0 || game_over !== 1'b0 || cleared !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got x=%0d y=%0d hit=%h busy=%b", ballx, bally, hit, busy);
    end
    @(negedge clk) rst = 1;
    model_reset();
    serve();
    advance(0, -1, n);
    total++;
    if (ballx !== 10'd322 || bally !== 10'd298) begin
      bad++;
      $display("FAIL after_reset got x=%0d y=%0d want 322 298", ballx, bally);
    end
  endtask

  task automatic test_back_to_back();
    int n, busy_seen;
    do_reset();
    serve();
    advance(0, 5, n);
    total++;
    if (n != 28 || ballx !== 10'd322 || bally !== 10'd298) begin
      bad++;
      $display("FAIL busy_tick got n=%0d x=%0d y=%0d want 28 322 298", n, ballx, bally);
    end
    busy_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    total++;
    if (busy_seen != 0 || ballx !== 10'd322) begin
      bad++;
      $display("FAIL tick_not_queued got busy_cycles=%0d x=%0d want 0 322", busy_seen, ballx);
    end
    advance(0, -1, n);
    total++;
    if (ballx !== 10'd324 || bally !== 10'd296) begin
      bad++;
      $display("FAIL next_frame got x=%0d y=%0d want 324 296", ballx, bally);
    end
  endtask

  task automatic test_random_play();
    int n, pad, off, inj;
    do_reset();
    serve();
    for (int f = 0; f < 300; f++) begin
      if (mlost || mwin) begin
        serve();
        @(negedge clk);
        total++;
        if (game_over !== 1'b0 || cleared !== 1'b0 || hit !== mhit) begin
          bad++;
          $display("FAIL rand_serve f%0d got go=%b cl=%b hit=%h want hit=%h", f, game_over, cleared, hit, mhit);
        end
      end
      off = $urandom_range(0, 170);
      pad = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 479) : ((off > mx) ? 0 : mx - off);
      inj = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 20) : -1;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      advance(pad, inj, n);
      total++;
      if (n >= 64 || ballx !== 10'(mx) || bally !== 10'(my) || hit !== mhit || game_over !== mlost || cleared !== mwin) begin
        bad++;
        $display("FAIL rand f%0d pad=%0d got x=%0d y=%0d hit=%h go=%b cl=%b want x=%0d y=%0d hit=%h go=%b cl=%b",
                 f, pad, ballx, bally, hit, game_over, cleared, mx, my, mhit, mlost, mwin);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_brick_and_paddle_left();
    test_paddle_right();
    test_lost();
    test_wall();
    test_reset_mid_scan();
    test_back_to_back();
    test_random_play();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
